// File: rtl/ram_burst_ctrl.sv
// ram_burst_ctrl: read/write burst controller in front of a synchronous
// single-port RAM with a one-cycle registered read. Write beats stream straight
// into the RAM. Read beats return through a small backpressured FIFO, and the
// controller never issues more reads than the FIFO can hold.
// Optional feature: define RAM_BURST_BOUND_CHECK_EN to reject bursts that run
// past the top of the address space (err pulse). Without it, bursts wrap.
module ram_burst_ctrl #(
    parameter int ADDR_W        = 9,
    parameter int DATA_W        = 32,
    parameter int RD_FIFO_DEPTH = 4
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              cmdValid,
    output logic              cmdReady,
    input  logic              cmdWrite,
    input  logic [ADDR_W-1:0] cmdAddr,
    input  logic [ADDR_W-1:0] cmdLen,
    input  logic              wdValid,
    output logic              wdReady,
    input  logic [DATA_W-1:0] wdData,
    output logic              rdValid,
    input  logic              rdReady,
    output logic [DATA_W-1:0] rdData,
    output logic              rdLast,
    output logic              busy,
    output logic              err,
    output logic [ADDR_W-1:0] ramAddr,
    output logic              ramWEn,
    output logic [DATA_W-1:0] ramWDat,
    output logic              ramREn,
    input  logic [DATA_W-1:0] ramRDat
);

    localparam int PTR_W = $clog2(RD_FIFO_DEPTH);
    localparam logic [PTR_W+1:0] DEPTH_W = (PTR_W + 2)'(RD_FIFO_DEPTH);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WRITE,
        ST_READ
    } state_t;

    state_t              state_q, state_d;
    logic [ADDR_W-1:0]   cur_addr_q, cur_addr_d;
    logic [ADDR_W:0]     remain_q, remain_d;
    logic [ADDR_W:0]     len_q, len_d;
    logic [ADDR_W:0]     issued_q, issued_d;
    logic                inflight_q, inflight_d;
    logic                inflight_last_q, inflight_last_d;
`ifdef RAM_BURST_BOUND_CHECK_EN
    logic                err_q, err_d;
`endif

    // Read-return FIFO: storage plus pointers and occupancy.
    logic [DATA_W-1:0]   fifo_data [RD_FIFO_DEPTH];
    logic                fifo_last [RD_FIFO_DEPTH];
    logic [PTR_W-1:0]    wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]    rd_ptr_q, rd_ptr_d;
    logic [PTR_W:0]      count_q, count_d;

    logic                issue;
    logic                push;
    logic                pop;

    // Next-state, FIFO bookkeeping and all outputs; reset forces outputs to 0.
    always_comb begin
        // NOTE: every signal gets a default before any branch so no latch can be inferred.
        state_d         = state_q;
        cur_addr_d      = cur_addr_q;
        remain_d        = remain_q;
        len_d           = len_q;
        issued_d        = issued_q;
        inflight_d      = 1'b0;
        inflight_last_d = 1'b0;
`ifdef RAM_BURST_BOUND_CHECK_EN
        err_d           = 1'b0;
`endif
        cmdReady = 1'b0;
        wdReady  = 1'b0;
        rdValid  = 1'b0;
        rdData   = '0;
        rdLast   = 1'b0;
        busy     = 1'b0;
        err      = 1'b0;
        ramAddr  = '0;
        ramWEn   = 1'b0;
        ramWDat  = '0;
        ramREn   = 1'b0;
        issue    = 1'b0;
        pop      = 1'b0;
        // The RAM returns data the cycle after an issue; it always lands in the FIFO.
        push     = inflight_q;

        if (!reset) begin
            rdValid = (count_q != '0);
            rdData  = fifo_data[rd_ptr_q];
            rdLast  = fifo_last[rd_ptr_q];
            busy    = (state_q != ST_IDLE) || (count_q != '0);
`ifdef RAM_BURST_BOUND_CHECK_EN
            err     = err_q;
`endif
            pop     = rdValid && rdReady;

            case (state_q)
                ST_IDLE: begin
                    cmdReady = 1'b1;
                    if (cmdValid) begin
`ifdef RAM_BURST_BOUND_CHECK_EN
                        if (({1'b0, cmdAddr} + {1'b0, cmdLen}) > {1'b0, {ADDR_W{1'b1}}}) begin
                            err_d = 1'b1;
                        end else begin
                            cur_addr_d = cmdAddr;
                            remain_d   = {1'b0, cmdLen};
                            len_d      = {1'b0, cmdLen};
                            issued_d   = '0;
                            state_d    = cmdWrite ? ST_WRITE : ST_READ;
                        end
`else
                        cur_addr_d = cmdAddr;
                        remain_d   = {1'b0, cmdLen};
                        len_d      = {1'b0, cmdLen};
                        issued_d   = '0;
                        state_d    = cmdWrite ? ST_WRITE : ST_READ;
`endif
                    end
                end

                ST_WRITE: begin
                    wdReady = 1'b1;
                    ramAddr = cur_addr_q;
                    ramWDat = wdData;
                    ramWEn  = wdValid;
                    if (wdValid) begin
                        cur_addr_d = cur_addr_q + ADDR_W'(1);
                        remain_d   = remain_q - (ADDR_W + 1)'(1);
                        if (remain_q == '0) begin
                            state_d = ST_IDLE;
                        end
                    end
                end

                ST_READ: begin
                    ramAddr = cur_addr_q;
                    // Only issue while the FIFO can absorb every read already in flight.
                    issue = (issued_q <= len_q) &&
                            (({1'b0, count_q} + {{(PTR_W + 1){1'b0}}, inflight_q}) < DEPTH_W);
                    ramREn = issue;
                    if (issue) begin
                        cur_addr_d = cur_addr_q + ADDR_W'(1);
                        issued_d   = issued_q + (ADDR_W + 1)'(1);
                    end
                    inflight_d      = issue;
                    inflight_last_d = issue && (issued_q == len_q);
                    if (pop && fifo_last[rd_ptr_q]) begin
                        state_d = ST_IDLE;
                    end
                end

                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end

        wr_ptr_d = push ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
        rd_ptr_d = pop  ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
        count_d  = count_q + {{PTR_W{1'b0}}, push} - {{PTR_W{1'b0}}, pop};
    end

    // Control state registers with synchronous reset.
    always_ff @(posedge clock) begin
        // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
        if (reset) begin
            state_q         <= ST_IDLE;
            cur_addr_q      <= '0;
            remain_q        <= '0;
            len_q           <= '0;
            issued_q        <= '0;
            inflight_q      <= 1'b0;
            inflight_last_q <= 1'b0;
            wr_ptr_q        <= '0;
            rd_ptr_q        <= '0;
            count_q         <= '0;
`ifdef RAM_BURST_BOUND_CHECK_EN
            err_q           <= 1'b0;
`endif
        end else begin
            state_q         <= state_d;
            cur_addr_q      <= cur_addr_d;
            remain_q        <= remain_d;
            len_q           <= len_d;
            issued_q        <= issued_d;
            inflight_q      <= inflight_d;
            inflight_last_q <= inflight_last_d;
            wr_ptr_q        <= wr_ptr_d;
            rd_ptr_q        <= rd_ptr_d;
            count_q         <= count_d;
`ifdef RAM_BURST_BOUND_CHECK_EN
            err_q           <= err_d;
`endif
        end
    end

    // FIFO storage: capture the RAM read data and its last tag on each push.
    always_ff @(posedge clock) begin
        // NOTE: storage is not reset; the pointers and count define which entries are valid.
        if (push) begin
            fifo_data[wr_ptr_q] <= ramRDat;
            fifo_last[wr_ptr_q] <= inflight_last_q;
        end
    end

endmodule

// File: doc/ram_burst_ctrl.md
# ram_burst_ctrl

Burst controller sitting directly upstream of the 512×32 synchronous single-port RAM. It accepts read or write burst commands on a valid/ready command port. It streams write beats from a producer into the RAM and returns read beats through a backpressured output FIFO. It hides the RAM's one-cycle registered read latency and its write-over-read priority from the client.

## Interface
Parameters:
- ADDR_W, 9, RAM address width (depth 2^ADDR_W)
- DATA_W, 32, data width
- RD_FIFO_DEPTH, 4, read-return FIFO entries (power of two, ≥3)

Ports:
- clock  in  1  sole clock, rising edge
- reset  in  1  synchronous, active-high
- cmdValid  in  1  command offered
- cmdReady  out  1  command accepted when high with cmdValid
- cmdWrite  in  1  1 = write burst, 0 = read burst
- cmdAddr  in  ADDR_W  start address
- cmdLen  in  ADDR_W  beats minus one (0 → 1 beat, 511 → 512 beats)
- wdValid  in  1  write beat offered
- wdReady  out  1  write beat accepted
- wdData  in  DATA_W  write beat data
- rdValid  out  1  read beat available
- rdReady  in  1  read beat consumed
- rdData  out  DATA_W  read beat data
- rdLast  out  1  marks final beat of read burst
- busy  out  1  state ≠ IDLE or FIFO non-empty
- err  out  1  one-cycle pulse on rejected command (macro only)
- ramAddr  out  ADDR_W  to RAM addr
- ramWEn  out  1  to RAM wEn
- ramWDat  out  DATA_W  to RAM wDat
- ramREn  out  1  to RAM rEn
- ramRDat  in  DATA_W  from RAM rDat

## Operation
- States: IDLE, WRITE, READ.
- IDLE: cmdReady=1. On cmdValid: latch curAddr=cmdAddr and remain=cmdLen. Go to WRITE if cmdWrite=1, else READ.
- WRITE:
  - wdReady=1.
  - ramWEn=wdValid, ramAddr=curAddr, ramWDat=wdData (combinational; the write lands on the same edge that the beat is accepted).
  - Per accepted beat: curAddr+1 (mod 2^ADDR_W), remain−1.
  - Beat accepted with remain=0 → IDLE.
- READ:
  - ramREn=1 when issuing is allowed: issued<len+1 and fifoCount+inflight<RD_FIFO_DEPTH.
  - Each issue increments curAddr. inflight=1 in the cycle after an issue.
  - In that cycle ramRDat is pushed into the FIFO, tagged last if it is beat len.
  - After the last beat is popped (rdValid&rdReady&rdLast) → IDLE.
- ramWEn and ramREn are never high in the same cycle. ramWEn is never high outside WRITE, and ramREn is never high outside READ.
- rdData/rdLast come from the FIFO head. rdValid = FIFO non-empty.
- New commands are accepted only in IDLE. The FIFO is empty whenever the state is IDLE.
- Address arithmetic is modulo 2^ADDR_W. The counters are ADDR_W+1 bits so a 512-beat burst counts correctly.

## Timing
- Reset (while asserted and on the following edge):
  - state=IDLE, FIFO flushed, inflight=0.
  - All outputs 0, including cmdReady, ramWEn and ramREn.
  - cmdReady=1 in the first cycle after reset deasserts.
- Reset mid-burst aborts immediately. No RAM strobe is issued in the reset cycle, and RAM contents are untouched.
- Write latency: a beat accepted at edge E is in RAM at edge E. Peak throughput is 1 beat/cycle.
- Read latency:
  - Command accepted at edge N.
  - First ramREn in cycle N+1.
  - First rdValid in cycle N+3.
  - With rdReady held high, beats follow at 1/cycle with no bubbles.
- Backpressure: with rdReady low, issuing stops once fifoCount+inflight=RD_FIFO_DEPTH. No beat is ever dropped or duplicated.
- Handshake rules:
  - rdData and rdLast hold stable while rdValid=1 and rdReady=0.
  - cmdReady and wdReady do not depend on cmdValid or wdValid.
- Wrap-around: cmdAddr=510, cmdLen=3 accesses 510, 511, 0, 1 (without the macro).

## Configuration
- Macro RAM_BURST_BOUND_CHECK_EN.
- Defined:
  - A command with cmdAddr+cmdLen > 2^ADDR_W−1 is consumed in IDLE (cmdReady=1).
  - err pulses for exactly one cycle, the state stays IDLE, and no RAM access occurs.
- Undefined: err is tied to 0, and bursts wrap modulo 2^ADDR_W.

## Test plan
- Write 4 beats (0xA0..0xA3) at addr 8, then read addr 8 len 3 with rdReady=1 → ramWEn pulses at 8..11. Read returns A0..A3 with first rdValid 2 cycles after first ramREn, and rdLast on A3.
- Read 8 beats with rdReady held low for 10 cycles → ramREn stops after 4 issues and no beat is lost. After release, the data sequence is in order and complete.
- Write at 510 len 3 without the macro → writes land at 510, 511, 0, 1. With the macro defined, err=1 for one cycle, no ramWEn, cmdReady=1 next cycle.
- Assert reset mid-read (beat 2 of 6) → all outputs 0 in the next cycle and FIFO empty. cmdReady=1 once reset drops. A subsequent read returns correct data.
- Write burst with wdValid toggling every other cycle → ramWEn only on accepted beats and curAddr advances only on accepted beats. Readback matches.
- Full 512-beat burst (cmdLen=511) write then read → all 512 locations verified, single rdLast on the final beat.
